// File: rtl/next_pc_ctrl.sv
// Multi-cycle next-PC controller: sequences IF/ID/EXE/MEM/WB/HALT and computes
// the registered next-PC value with a one-cycle PC write pulse per retired instruction.
module next_pc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] CurPC,
    input  logic        instr_valid,
    input  logic [2:0]  op_class,
    input  logic        br_ne,
    input  logic        zero,
    input  logic        mem_op,
    input  logic        wb_en,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    output logic [31:0] NextPC,
    output logic        PCWre,
    output logic        IRWre,
    output logic [2:0]  stage,
    output logic        halted
);

    localparam int unsigned PC_W = 32;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JR     = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  next_pc_q, next_pc_d;
    logic [PC_W-1:0]  pc4_q, pc4_d;
    logic             pcwre_q, pcwre_d;
    logic             fetch;
    logic             taken;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  j_target;

    // Fetch is blocked during reset and during the PC write cycle
    assign fetch     = rst && (state_q == S_IF) && instr_valid && !pcwre_q;
    assign br_target = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_target  = {pc4_q[31:28], jaddr, 2'b00};

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        pc4_d     = pc4_q;
        pcwre_d   = 1'b0;
        taken     = zero ^ br_ne;
        case (state_q)
            S_IF: begin
                if (fetch) begin
                    pc4_d   = CurPC + PC_W'(4);
                    state_d = S_ID;
                end
            end
            S_ID: begin
                case (op_class)
                    OP_JUMP: begin
                        next_pc_d = j_target;
                        pcwre_d   = 1'b1;
                        state_d   = S_IF;
                    end
                    OP_JR: begin
                        next_pc_d = rs_data;
                        pcwre_d   = 1'b1;
                        state_d   = S_IF;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                if (op_class == OP_BRANCH) begin
                    next_pc_d = taken ? br_target : pc4_q;
                    pcwre_d   = 1'b1;
                    state_d   = S_IF;
                end else if (mem_op) begin
                    state_d = S_MEM;
                end else if (wb_en) begin
                    state_d = S_WB;
                end else begin
                    next_pc_d = pc4_q;
                    pcwre_d   = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_MEM: begin
                if (wb_en) begin
                    state_d = S_WB;
                end else begin
                    next_pc_d = pc4_q;
                    pcwre_d   = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_WB: begin
                next_pc_d = pc4_q;
                pcwre_d   = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Synchronous active-low reset discards any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IF;
            next_pc_q <= '0;
            pc4_q     <= '0;
            pcwre_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            pc4_q     <= pc4_d;
            pcwre_q   <= pcwre_d;
        end
    end

    assign NextPC = next_pc_q;
    assign PCWre  = pcwre_q;
    assign IRWre  = fetch;
    assign stage  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed self-checking bench for next_pc_ctrl.
module tb_next_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] CurPC;
    logic        instr_valid;
    logic [2:0]  op_class;
    logic        br_ne;
    logic        zero;
    logic        mem_op;
    logic        wb_en;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] rs_data;
    logic [31:0] NextPC;
    logic        PCWre;
    logic        IRWre;
    logic [2:0]  stage;
    logic        halted;

    int checks = 0;
    int errors = 0;

    next_pc_ctrl dut (
        .clk(clk), .rst(rst), .CurPC(CurPC), .instr_valid(instr_valid),
        .op_class(op_class), .br_ne(br_ne), .zero(zero), .mem_op(mem_op),
        .wb_en(wb_en), .imm16(imm16), .jaddr(jaddr), .rs_data(rs_data),
        .NextPC(NextPC), .PCWre(PCWre), .IRWre(IRWre), .stage(stage),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [2:0] opc,
                             input logic m, input logic w);
        CurPC = pc; op_class = opc; mem_op = m; wb_en = w; instr_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b0; CurPC = '0; instr_valid = 1'b1; op_class = '0; br_ne = 1'b0;
        zero = 1'b0; mem_op = 1'b0; wb_en = 1'b0; imm16 = '0; jaddr = '0; rs_data = '0;

        // Reset state, IRWre forced low while rst=0
        tick();
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_nextpc", NextPC, 32'h0);
        chk("rst_pcwre", 32'(PCWre), 32'd0);
        chk("rst_irwre", 32'(IRWre), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Seq ALU op with writeback
        rst = 1'b1;
        set_instr(32'h10, 3'd0, 1'b0, 1'b1);
        #1;
        chk("seq_irwre", 32'(IRWre), 32'd1);
        tick(); chk("seq_id", 32'(stage), 32'd1);
        chk("seq_irwre_id", 32'(IRWre), 32'd0);
        tick(); chk("seq_exe", 32'(stage), 32'd2);
        tick(); chk("seq_wb", 32'(stage), 32'd4);
        chk("seq_pcwre_pre", 32'(PCWre), 32'd0);
        tick(); chk("seq_if", 32'(stage), 32'd0);
        chk("seq_pcwre", 32'(PCWre), 32'd1);
        chk("seq_nextpc", NextPC, 32'h14);
        chk("seq_irwre_blocked", 32'(IRWre), 32'd0);

        // beq taken
        set_instr(32'h20, 3'd1, 1'b0, 1'b0);
        imm16 = 16'hFFFE; zero = 1'b1; br_ne = 1'b0;
        tick(); chk("beqt_pcwre_low", 32'(PCWre), 32'd0);
        chk("beqt_irwre", 32'(IRWre), 32'd1);
        tick(); chk("beqt_id", 32'(stage), 32'd1);
        tick(); chk("beqt_exe", 32'(stage), 32'd2);
        tick(); chk("beqt_pcwre", 32'(PCWre), 32'd1);
        chk("beqt_nextpc", NextPC, 32'h1C);

        // beq not taken
        zero = 1'b0;
        tick(); tick(); tick(); tick();
        chk("beqn_pcwre", 32'(PCWre), 32'd1);
        chk("beqn_nextpc", NextPC, 32'h24);

        // bne taken (zero=0, br_ne=1)
        br_ne = 1'b1;
        tick(); tick(); tick(); tick();
        chk("bne_nextpc", NextPC, 32'h1C);
        br_ne = 1'b0;

        // Jump
        set_instr(32'hF000_0000, 3'd2, 1'b0, 1'b0);
        jaddr = 26'h0000100;
        tick(); tick(); chk("j_id", 32'(stage), 32'd1);
        tick(); chk("j_if", 32'(stage), 32'd0);
        chk("j_pcwre", 32'(PCWre), 32'd1);
        chk("j_nextpc", NextPC, 32'hF000_0400);
        tick(); chk("j_pcwre_pulse", 32'(PCWre), 32'd0);
        chk("j_hold", NextPC, 32'hF000_0400);

        // jr
        set_instr(32'h40, 3'd3, 1'b0, 1'b0);
        rs_data = 32'h1234_5678;
        tick(); tick();
        chk("jr_pcwre", 32'(PCWre), 32'd1);
        chk("jr_nextpc", NextPC, 32'h1234_5678);

        // Halt is absorbing, then reset mid-HALT
        set_instr(32'h80, 3'd4, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("halt_stage", 32'(stage), 32'd5);
        chk("halt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_pcwre", 32'(PCWre), 32'd0);
            chk("halt_irwre", 32'(IRWre), 32'd0);
            chk("halt_stay", 32'(stage), 32'd5);
        end
        chk("halt_nextpc", NextPC, 32'h1234_5678);
        rst = 1'b0;
        tick(); rst = 1'b1;
        chk("halt_rst_stage", 32'(stage), 32'd0);
        chk("halt_rst_nextpc", NextPC, 32'h0);
        chk("halt_rst_halted", 32'(halted), 32'd0);

        // Stall in IF
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_irwre", 32'(IRWre), 32'd0);
            tick();
            chk("stall_stage", 32'(stage), 32'd0);
        end

        // Wrap with load through MEM and WB
        set_instr(32'hFFFF_FFFC, 3'd0, 1'b1, 1'b1);
        tick(); chk("wrap_id", 32'(stage), 32'd1);
        tick(); chk("wrap_exe", 32'(stage), 32'd2);
        tick(); chk("wrap_mem", 32'(stage), 32'd3);
        tick(); chk("wrap_wb", 32'(stage), 32'd4);
        tick(); chk("wrap_if", 32'(stage), 32'd0);
        chk("wrap_pcwre", 32'(PCWre), 32'd1);
        chk("wrap_nextpc", NextPC, 32'h0);

        // Store (MEM without WB) retires from MEM
        set_instr(32'h200, 3'd0, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        chk("st_mem", 32'(stage), 32'd3);
        tick(); chk("st_pcwre", 32'(PCWre), 32'd1);
        chk("st_nextpc", NextPC, 32'h204);

        // Reset in EXE discards the pending retirement
        set_instr(32'h100, 3'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("rexe_exe", 32'(stage), 32'd2);
        rst = 1'b0;
        tick(); rst = 1'b1; instr_valid = 1'b0;
        chk("rexe_stage", 32'(stage), 32'd0);
        chk("rexe_pcwre", 32'(PCWre), 32'd0);
        chk("rexe_nextpc", NextPC, 32'h0);
        tick();
        chk("rexe_pcwre2", 32'(PCWre), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 SHALL provide clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide rst  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-003 SHALL provide CurPC  input  32  current program counter value from the PC register.
REQ-004 SHALL provide instr_valid  input  1  instruction memory data valid for CurPC.
REQ-005 SHALL provide op_class  input  3  decoded class: 0 seq, 1 branch, 2 jump, 3 jr, 4 halt, 5-7 treated as seq.
REQ-006 SHALL provide br_ne  input  1  branch sense: 0 taken when zero=1 (beq), 1 taken when zero=0 (bne).
REQ-007 SHALL provide zero  input  1  ALU zero flag, valid in EXE.
REQ-008 SHALL provide mem_op  input  1  instruction requires MEM stage.
REQ-009 SHALL provide wb_en  input  1  instruction requires WB stage.
REQ-010 SHALL provide imm16  input  16  branch offset in words.
REQ-011 SHALL provide jaddr  input  26  jump target field.
REQ-012 SHALL provide rs_data  input  32  register rs value for jr, valid in ID.
REQ-013 SHALL provide NextPC  output  32  registered next-PC value presented to PC register.
REQ-014 SHALL provide PCWre  output  1  PC write enable, one-cycle pulse per retired instruction.
REQ-015 SHALL provide IRWre  output  1  instruction register load strobe.
REQ-016 SHALL provide stage  output  3  current state encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-017 SHALL provide halted  output  1  high while in HALT.

Function
REQ-018 SHALL implement FSM states IF, ID, EXE, MEM, WB, HALT; stage output equals state register.
REQ-019 IF: SHALL stay in IF while instr_valid=0; on instr_valid=1 SHALL assert IRWre that cycle, register pc4 = CurPC+4 (mod 2^32), move to ID.
REQ-020 ID, op_class=2: SHALL register NextPC = {pc4[31:28], jaddr, 2'b00}, assert PCWre next cycle, return to IF.
REQ-021 ID, op_class=3: SHALL register NextPC = rs_data, same PCWre/IF handling as jump.
REQ-022 ID, op_class=4: SHALL go to HALT without PCWre; NextPC unchanged.
REQ-023 ID, other classes: SHALL go to EXE.
REQ-024 EXE, op_class=1: taken = zero XOR br_ne; SHALL register NextPC = pc4 + (sign-extended imm16 << 2) if taken else pc4, wrap mod 2^32, then PCWre, IF.
REQ-025 EXE, non-branch: mem_op=1 -> MEM; else wb_en=1 -> WB; else NextPC = pc4, PCWre, IF.
REQ-026 MEM: wb_en=1 -> WB; else NextPC = pc4, PCWre, IF.
REQ-027 WB: SHALL register NextPC = pc4, PCWre, go to IF.
REQ-028 PCWre SHALL be a registered pulse, high exactly one cycle, the cycle after the retiring-stage decision, coincident with state=IF and NextPC already stable; PC therefore loads NextPC at the end of that cycle.
REQ-029 While PCWre=1 in IF, instr_valid SHALL be ignored (no IRWre, no pc4 update); fetch acceptance resumes the following cycle.
REQ-030 IRWre SHALL be high only in IF with instr_valid=1 and PCWre=0; never two consecutive cycles.
REQ-031 NextPC SHALL hold its value between updates.
REQ-032 HALT SHALL be absorbing: no PCWre, no IRWre; exit only via reset.
REQ-033 Unused stage codes 6-7 SHALL transition to IF on the next edge with all strobes low.

Reset
REQ-034 On rising clk with rst=0: state=IF, NextPC=0, pc4=0, PCWre=0, IRWre=0 (combinational strobe forced low), halted=0, stage=0.
REQ-035 Reset SHALL override any stage mid-instruction including HALT; pending PCWre pulse SHALL be discarded.
REQ-036 First fetch after reset SHALL start the cycle after rst returns to 1.

Verification
REQ-037 Seq ALU op: CurPC=0x00000010, instr_valid=1, op_class=0, mem_op=0, wb_en=1 -> stages IF,ID,EXE,WB,IF; PCWre one cycle with NextPC=0x00000014.
REQ-038 beq taken: CurPC=0x00000020, imm16=0xFFFE, zero=1, br_ne=0 -> NextPC=0x0000001C, PCWre after EXE; with zero=0 -> NextPC=0x00000024.
REQ-039 Jump/jr: CurPC=0xF0000000, jaddr=0x0000100 -> NextPC=0xF0000400 after ID; jr rs_data=0x12345678 -> NextPC=0x12345678.
REQ-040 Wrap: CurPC=0xFFFFFFFC, seq op, load (mem_op=1, wb_en=1) -> stages IF,ID,EXE,MEM,WB,IF, NextPC=0x00000000.
REQ-041 Halt then reset: op_class=4 -> stage=5, halted=1, no PCWre for 10 cycles; rst=0 one cycle mid-HALT -> stage=0, NextPC=0, halted=0.
REQ-042 Stall: instr_valid=0 for 5 cycles in IF -> stage stays 0, IRWre=0; reset asserted in EXE -> no PCWre, state IF.
